rx_threshold_calibrator: RTL and testbench
==========================================

# rx_threshold_calibrator

Closed-loop calibration controller for the current-integrating receiver's sense-amp threshold. It drives the receiver's threshold code input and consumes the receiver's sampled output bit, with one sample per sense-amp sampling period. It sweeps the threshold code against a DC-balanced training stream and measures the ones density at each code. It then settles on the centre of the first passing run of codes. If no code passes, it falls back to the preset code.

## Interface
Parameters:
- CODE_WIDTH, 4, width of threshold code; sweep range 0..2^CODE_WIDTH-1
- PRESET_CODE, 5, code driven out of reset and on calibration failure
- WINDOW_LOG2, 6, samples counted per code = 2^WINDOW_LOG2
- SETTLE_SAMPLES, 4, valid samples discarded after each code change
- TOL, 2, allowed deviation of ones count from 2^(WINDOW_LOG2-1)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin calibration
- sample_valid  in  1  strobe, one cycle per receiver decision
- sample_bit  in  1  receiver output bit, qualified by sample_valid
- threshold_code  out  CODE_WIDTH  threshold to receiver
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when calibration completes
- cal_fail  out  1  sticky; set when no code passed, cleared on next start

## Operation
- States: IDLE, SETTLE, COUNT, EVAL, FINISH.
- IDLE:
  - start=1 → code:=0, clear lo/hi/found, cal_fail:=0, go to SETTLE.
  - start while busy is ignored.
- SETTLE: count SETTLE_SAMPLES valid samples (bits ignored), then go to COUNT with ones:=0 and n:=0.
- COUNT: on each sample_valid, ones += sample_bit and n += 1. When n reaches 2^WINDOW_LOG2, go to EVAL.
- EVAL (one cycle):
  - pass = |ones − 2^(WINDOW_LOG2-1)| ≤ TOL.
  - pass && !found → lo:=code, hi:=code, found:=1.
  - pass && found → hi:=code.
  - !pass && found → end of first run, go to FINISH (early exit).
  - Otherwise, if code is max → FINISH; else code+=1 and go to SETTLE.
- FINISH (one cycle):
  - found → threshold_code := (lo+hi)>>1, computed at CODE_WIDTH+1 bits then truncated (floor).
  - !found → threshold_code := PRESET_CODE and cal_fail := 1.
  - Pulse done, go to IDLE.
- Only the first contiguous passing run is used; later passing codes are never examined.
- Ones counter is WINDOW_LOG2+1 bits wide so a full window of ones does not wrap.
- The code never wraps; max code is the last code evaluated.

## Timing
- Reset values: threshold_code=PRESET_CODE, busy=0, done=0, cal_fail=0, state=IDLE.
- Reset mid-calibration aborts immediately to these values with no done pulse.
- busy rises the cycle after start is sampled and falls in the same cycle done is high.
- threshold_code changes on the clk edge that enters SETTLE; its new value is registered and stable for the whole SETTLE+COUNT interval of that code.
- The final threshold_code is updated on the edge entering FINISH and held until the next start or reset.
- Per-code cost: SETTLE_SAMPLES + 2^WINDOW_LOG2 valid samples, plus 1 EVAL cycle and 1 SETTLE-entry cycle.
- sample_valid during IDLE, EVAL or FINISH is dropped.
- A sample_valid arriving in the SETTLE-entry cycle counts toward settle.
- start arriving in the same cycle as done is ignored; start must be reissued.

## Structure
- Shared package holds:
  - state enum (IDLE/SETTLE/COUNT/EVAL/FINISH)
  - a default-code constant matching the receiver preset (5)
- One natural sub-module: rx_window_counter (settle/window sample counter plus ones accumulator, cleared per code, raises window_full).
- The FSM, lo/hi registers and midpoint logic stay in the top module.

## Test plan
- Reset: assert rst mid-COUNT → threshold_code=5, busy=0, done never pulses; the next start restarts from code 0.
- Ideal receiver model (density 50% for codes 6..9, ~100% below 6, ~0% above 9), default params → done after code 10 is evaluated (early exit), threshold_code=7, cal_fail=0.
- Passing region only at code 15 → lo=hi=15, threshold_code=15, sweep ends at max code with no wrap.
- No code passes (sample_bit tied to 1) → all 16 codes swept, threshold_code=5, cal_fail=1, one done pulse.
- Tolerance boundary with WINDOW_LOG2=6, TOL=2: ones=34 passes, ones=35 fails. Window of all 64 ones → counter reads 64 without wrapping.
- start asserted while busy, and again in the done cycle → both ignored; busy profile and done count unchanged.

Source files
------------

// File: rtl/rx_threshold_calibrator_pkg.sv
// Shared types and constants for the receiver threshold calibrator.
package rx_threshold_calibrator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    EVAL,
    FINISH
  } cal_state_t;

  // Receiver's own preset threshold code; used out of reset and on failure.
  localparam int unsigned DEFAULT_CODE = 5;

endpackage

// File: rtl/rx_window_counter.sv
// Per-code sample counter: discards settle samples, then counts a window of
// samples and accumulates ones. Cleared whenever a new code is applied.
module rx_window_counter #(
  parameter int unsigned WINDOW_LOG2    = 6,
  parameter int unsigned SETTLE_SAMPLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 settle_en,
  input  logic                 count_en,
  input  logic                 sample_valid,
  input  logic                 sample_bit,
  output logic                 settle_done,
  output logic                 window_full,
  output logic [WINDOW_LOG2:0] ones
);

  localparam int unsigned SW          = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1;
  localparam logic [WINDOW_LOG2:0] WINDOW_LAST = (WINDOW_LOG2 + 1)'((2 ** WINDOW_LOG2) - 1);

  logic [SW-1:0]        settle_cnt;
  logic [WINDOW_LOG2:0] n;

  // Strobes mark the sample that completes the settle phase / the window,
  // so the FSM leaves the phase on the same edge that sample is absorbed.
  always_comb begin
    settle_done = 1'b0;
    window_full = 1'b0;
    if (SETTLE_SAMPLES == 0) begin
      settle_done = settle_en;
    end else begin
      settle_done = settle_en && sample_valid && (settle_cnt == SW'(SETTLE_LAST));
    end
    window_full = count_en && sample_valid && (n == WINDOW_LAST);
  end

  // Settle counter, window sample counter and ones accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      n          <= '0;
      ones       <= '0;
    end else if (clear) begin
      settle_cnt <= '0;
      n          <= '0;
      ones       <= '0;
    end else begin
      if (settle_en && sample_valid) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (count_en && sample_valid) begin
        n    <= n + 1'b1;
        ones <= ones + (WINDOW_LOG2 + 1)'(sample_bit);
      end
    end
  end

endmodule

// File: rtl/rx_threshold_calibrator.sv
// Sense-amp threshold calibrator: sweeps the threshold code, measures ones
// density per code and settles on the centre of the first passing run.
module rx_threshold_calibrator
  import rx_threshold_calibrator_pkg::*;
#(
  parameter int unsigned CODE_WIDTH     = 4,
  parameter int unsigned PRESET_CODE    = DEFAULT_CODE,
  parameter int unsigned WINDOW_LOG2    = 6,
  parameter int unsigned SETTLE_SAMPLES = 4,
  parameter int unsigned TOL            = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic                  sample_bit,
  output logic [CODE_WIDTH-1:0] threshold_code,
  output logic                  busy,
  output logic                  done,
  output logic                  cal_fail
);

  localparam logic [WINDOW_LOG2:0]  HALF_V   = (WINDOW_LOG2 + 1)'(2 ** (WINDOW_LOG2 - 1));
  localparam logic [CODE_WIDTH-1:0] MAX_CODE = '1;
  localparam logic [CODE_WIDTH-1:0] PRESET_V = CODE_WIDTH'(PRESET_CODE);

  cal_state_t            state;
  logic [CODE_WIDTH-1:0] code;
  logic [CODE_WIDTH-1:0] lo;
  logic [CODE_WIDTH-1:0] hi;
  logic                  found;

  logic                  settle_done;
  logic                  window_full;
  logic [WINDOW_LOG2:0]  ones;

  logic [WINDOW_LOG2:0]  dev;
  logic                  pass;
  logic                  found_nxt;
  logic [CODE_WIDTH-1:0] lo_nxt;
  logic [CODE_WIDTH-1:0] hi_nxt;
  logic [CODE_WIDTH-1:0] mid;
  logic                  eval_finish;
  logic                  clear;

  rx_window_counter #(
    .WINDOW_LOG2   (WINDOW_LOG2),
    .SETTLE_SAMPLES(SETTLE_SAMPLES)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .settle_en   (state == SETTLE),
    .count_en    (state == COUNT),
    .sample_valid(sample_valid),
    .sample_bit  (sample_bit),
    .settle_done (settle_done),
    .window_full (window_full),
    .ones        (ones)
  );

  // Evaluation of the finished window; lo/hi are looked ahead so the final
  // midpoint can be registered on the edge that enters FINISH.
  always_comb begin
    dev         = (ones >= HALF_V) ? (ones - HALF_V) : (HALF_V - ones);
    pass        = (32'(dev) <= TOL);
    found_nxt   = found | pass;
    lo_nxt      = (pass && !found) ? code : lo;
    hi_nxt      = pass ? code : hi;
    mid         = CODE_WIDTH'(({1'b0, lo_nxt} + {1'b0, hi_nxt}) >> 1);
    eval_finish = (!pass && found) || (code == MAX_CODE);
    clear       = ((state == IDLE) && start) || ((state == EVAL) && !eval_finish);
  end

  // Calibration FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      code           <= '0;
      lo             <= '0;
      hi             <= '0;
      found          <= 1'b0;
      threshold_code <= PRESET_V;
      busy           <= 1'b0;
      done           <= 1'b0;
      cal_fail       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            code           <= '0;
            threshold_code <= '0;
            lo             <= '0;
            hi             <= '0;
            found          <= 1'b0;
            cal_fail       <= 1'b0;
            busy           <= 1'b1;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            state <= COUNT;
          end
        end
        COUNT: begin
          if (window_full) begin
            state <= EVAL;
          end
        end
        EVAL: begin
          lo    <= lo_nxt;
          hi    <= hi_nxt;
          found <= found_nxt;
          if (eval_finish) begin
            threshold_code <= found_nxt ? mid : PRESET_V;
            cal_fail       <= !found_nxt;
            done           <= 1'b1;
            busy           <= 1'b0;
            state          <= FINISH;
          end else begin
            code           <= code + 1'b1;
            threshold_code <= code + 1'b1;
            state          <= SETTLE;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_threshold_calibrator.sv
// Bench for rx_threshold_calibrator: receiver model with per-code ones
// density, table of sweep profiles, scoreboard of expected results.
module tb_rx_threshold_calibrator;
  import rx_threshold_calibrator_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sample_valid;
  logic       sample_bit;
  logic [3:0] threshold_code;
  logic       busy;
  logic       done;
  logic       cal_fail;

  always #5 clk = ~clk;

  rx_threshold_calibrator #(
    .CODE_WIDTH    (4),
    .PRESET_CODE   (5),
    .WINDOW_LOG2   (6),
    .SETTLE_SAMPLES(4),
    .TOL           (2)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sample_valid  (sample_valid),
    .sample_bit    (sample_bit),
    .threshold_code(threshold_code),
    .busy          (busy),
    .done          (done),
    .cal_fail      (cal_fail)
  );

  typedef struct {
    int plo;       // first code of the main passing region
    int phi;       // last code of the main passing region
    int mid_t;     // ones per 64 inside the region
    int below_t;   // ones per 64 below the region
    int above_t;   // ones per 64 above the region
    int p2;        // isolated extra code with 32/64 ones (-1: none)
    int exp_code;
    int exp_fail;
    int exp_codes; // number of codes the sweep applies
    int poke;      // issue start while busy and in the done cycle
    int full_chk;  // check accumulator reaches 64 at every EVAL
  } vec_t;

  typedef struct {
    int code;
    int fail;
    int codes;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  int          checks = 0;
  int          passes = 0;
  int          done_cnt = 0;
  int          codes_seen = 0;
  bit          seq_ok = 1'b1;
  bit          check_full = 1'b0;
  bit          rx_en = 1'b0;
  int unsigned k = 0;
  int          r_plo, r_phi, r_mid, r_below, r_above, r_p2;
  logic [3:0]  prev_code = 4'd0;
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int density(input int c);
    if (c == r_p2) return 32;
    if (c < r_plo) return r_below;
    if (c > r_phi) return r_above;
    return r_mid;
  endfunction

  // Receiver: any 64 consecutive valid samples at one code hold exactly
  // density(code) ones, so window alignment does not matter.
  initial begin
    sample_valid = 1'b0;
    sample_bit   = 1'b0;
    forever begin
      int t;
      @(negedge clk);
      if (rx_en && ($urandom_range(0, 3) != 0)) begin
        t            = density(int'(threshold_code));
        sample_valid = 1'b1;
        sample_bit   = ((((k + 1) * t) / 64) - ((k * t) / 64)) != 0;
        k++;
      end else begin
        sample_valid = 1'b0;
        sample_bit   = $urandom_range(0, 1);
      end
    end
  end

  // Monitor: tracks the code sequence and scores each done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !prev_busy) begin
        codes_seen = 1;
        seq_ok     = (threshold_code == 4'd0);
      end else if (busy && (threshold_code != prev_code)) begin
        codes_seen++;
        if (int'(threshold_code) != int'(prev_code) + 1) seq_ok = 1'b0;
      end
      if (check_full && (u_dut.state == EVAL))
        check("full_window_ones", int'(u_dut.u_counter.ones), 64);
      if (done) begin
        done_cnt++;
        check("busy_low_with_done", int'(busy), 0);
        check("busy_high_before_done", int'(prev_busy), 1);
        check("done_expected", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("final_code", int'(threshold_code), e.code);
          check("cal_fail", int'(cal_fail), e.fail);
          check("codes_swept", codes_seen, e.codes);
          check("code_sequence", int'(seq_ok), 1);
        end
      end
    end
    prev_code = threshold_code;
    prev_busy = busy;
  end

  task automatic set_profile(input int i);
    r_plo      = vecs[i].plo;
    r_phi      = vecs[i].phi;
    r_mid      = vecs[i].mid_t;
    r_below    = vecs[i].below_t;
    r_above    = vecs[i].above_t;
    r_p2       = vecs[i].p2;
    check_full = (vecs[i].full_chk != 0);
  endtask

  task automatic run_vec(input int i);
    int d0;
    int busy_seen;
    bit got;
    set_profile(i);
    sb.push_back('{code: vecs[i].exp_code, fail: vecs[i].exp_fail, codes: vecs[i].exp_codes});
    @(negedge clk);
    #1;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", int'(busy), 1);
    got = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (vecs[i].poke != 0 && c == 150) start = 1'b1;
      else start = 1'b0;
      if (done) begin
        got = 1'b1;
        if (vecs[i].poke != 0) start = 1'b1;
        break;
      end
    end
    check("done_within_budget", int'(got), 1);
    @(negedge clk);
    start = 1'b0;
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    #1;
    check("no_restart_after_done", busy_seen, 0);
    check("done_once", done_cnt - d0, 1);
    check("code_held", int'(threshold_code), vecs[i].exp_code);
    check_full = 1'b0;
  endtask

  initial begin
    //          plo phi mid below above p2  code fail codes poke full
    vecs[0] = '{6,  9,  32, 64,   0,    14, 7,   0,   11,   1,   0};
    vecs[1] = '{15, 15, 33, 64,   0,    -1, 15,  0,   16,   0,   0};
    vecs[2] = '{0,  15, 64, 64,   64,   -1, 5,   1,   16,   0,   1};
    vecs[3] = '{3,  9,  34, 35,   29,   -1, 6,   0,   11,   0,   0};
    vecs[4] = '{2,  3,  30, 29,   36,   -1, 2,   0,   5,    1,   0};
    vecs[5] = '{8,  13, 31, 0,    64,   -1, 10,  0,   15,   0,   0};
    vecs[6] = '{0,  0,  32, 0,    0,    -1, 0,   0,   2,    0,   0};

    rst   = 1'b1;
    start = 1'b0;
    set_profile(0);
    rx_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_code", int'(threshold_code), 5);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_cal_fail", int'(cal_fail), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Abort mid-COUNT at code 2, then restart from code 0.
    begin
      int  d0;
      int  busy_seen;
      bit  reached;
      set_profile(0);
      sb.push_back('{code: 7, fail: 0, codes: 11});
      d0    = done_cnt;
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        if (u_dut.state == COUNT && threshold_code == 4'd2) begin
          reached = 1'b1;
          break;
        end
      end
      check("reached_count_code2", int'(reached), 1);
      #2;
      rst = 1'b1;
      #1;
      check("abort_code", int'(threshold_code), 5);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      busy_seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (busy) busy_seen++;
      end
      #1;
      check("abort_stays_idle", busy_seen, 0);
      check("abort_no_done", done_cnt - d0, 0);
    end

    for (int i = 0; i < 7; i++) run_vec(i);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
